// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared types and helpers for the load/store data-memory controller.
`include "parameter_define.sv"

package lsu_dmem_ctrl_pkg;

    localparam logic [2:0] WHB_WORD  = `WORD;
    localparam logic [2:0] WHB_HALF  = `HALF;
    localparam logic [2:0] WHB_HALFU = `HALFU;
    localparam logic [2:0] WHB_BYTE  = `BYTE;
    localparam logic [2:0] WHB_BYTEU = `BYTEU;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

    // Size/alignment legality; unknown codes are never legal.
    function automatic logic access_legal(input logic [2:0] whb, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (whb)
            WHB_WORD:             ok = (off == 2'b00);
            WHB_HALF, WHB_HALFU:  ok = (off[0] == 1'b0);
            WHB_BYTE, WHB_BYTEU:  ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] whb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        case (whb)
            WHB_HALF, WHB_HALFU:  m = 32'h0000_FFFF;
            WHB_BYTE, WHB_BYTEU:  m = 32'h0000_00FF;
            default:              m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replication, load right-alignment.
module lsu_lane_align
    import lsu_dmem_ctrl_pkg::*;
(
    input  logic [2:0]  st_whb,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    input  logic [2:0]  ld_whb,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic [31:0] ld_aligned
);

    logic [31:0] ld_shift_s;

    // Store lane generation; unsigned size codes behave like their signed twins.
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = 32'h0000_0000;
        case (st_whb)
            WHB_BYTE, WHB_BYTEU: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            WHB_HALF, WHB_HALFU: begin
                st_be        = 4'b0011 << st_off;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            WHB_WORD: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: begin
                st_be        = 4'b0000;
                st_wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Load alignment; extension is left to the sign-extend stage, bits above the size are zero.
    always_comb begin
        ld_shift_s = ld_rdata >> {ld_off, 3'b000};
        ld_aligned = ld_shift_s & size_mask(ld_whb);
    end

endmodule

// File: rtl/parameter_define.sv
// Pipeline-wide access-size codes shared by the MEM stage and the load sign-extend stage.
`ifndef PARAMETER_DEFINE_SV
`define PARAMETER_DEFINE_SV
`define WORD  3'b000
`define HALF  3'b001
`define HALFU 3'b010
`define BYTE  3'b011
`define BYTEU 3'b100
`endif

// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store controller driving a variable-latency req/ack data-memory port.
module lsu_dmem_ctrl
    import lsu_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_whb,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        ld_valid,
    output logic [2:0]  ld_whb,
    output logic [31:0] ld_data,
    output logic        lsu_exc,
    output logic        bus_err
);

    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_r;
    lsu_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       lat_off_r;
    logic [2:0]       lat_whb_r;
    logic             lat_load_r;

    logic             legal_s;
    logic             accept_s;
    logic             illegal_s;
    logic             done_s;
    logic             timeout_s;

    logic [3:0]       st_be_s;
    logic [31:0]      st_wdata_s;
    logic [31:0]      ld_aligned_s;

    logic             dm_req_r;
    logic [3:0]       dm_we_r;
    logic [31:0]      dm_addr_r;
    logic [31:0]      dm_wdata_r;
    logic             ld_valid_r;
    logic [2:0]       ld_whb_r;
    logic [31:0]      ld_data_r;
    logic             lsu_exc_r;
    logic             bus_err_r;

    lsu_lane_align u_lane_align (
        .st_whb       (ex_whb),
        .st_off       (ex_addr[1:0]),
        .st_wdata     (ex_wdata),
        .ld_whb       (lat_whb_r),
        .ld_off       (lat_off_r),
        .ld_rdata     (dm_rdata),
        .st_be        (st_be_s),
        .st_wdata_rep (st_wdata_s),
        .ld_aligned   (ld_aligned_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        illegal_s   = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        legal_s     = access_legal(ex_whb, ex_addr[1:0]);
        case (state_r)
            ST_IDLE: begin
                if (ex_valid && (ex_load || ex_store)) begin
                    if ((ex_load ^ ex_store) && legal_s) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_REQ;
                    end else begin
                        illegal_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dm_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Stall covers the accept cycle combinationally so upstream freezes before the request launches.
    always_comb begin
        lsu_stall = 1'b0;
        if (accept_s || (state_r == ST_REQ)) begin
            lsu_stall = 1'b1;
        end else begin
            lsu_stall = 1'b0;
        end
    end

    // Wait counter: counts unacknowledged request cycles, cleared whenever not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_REQ) && !done_s && !timeout_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Request registers: capture the access on accept, release the request on ack or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req_r   <= 1'b0;
            dm_we_r    <= 4'b0000;
            dm_addr_r  <= 32'h0000_0000;
            dm_wdata_r <= 32'h0000_0000;
            lat_off_r  <= 2'b00;
            lat_whb_r  <= 3'b000;
            lat_load_r <= 1'b0;
        end else if (accept_s) begin
            dm_req_r   <= 1'b1;
            dm_we_r    <= ex_store ? st_be_s : 4'b0000;
            dm_addr_r  <= {ex_addr[31:2], 2'b00};
            dm_wdata_r <= ex_store ? st_wdata_s : 32'h0000_0000;
            lat_off_r  <= ex_addr[1:0];
            lat_whb_r  <= ex_whb;
            lat_load_r <= ex_load;
        end else if (done_s || timeout_s) begin
            dm_req_r   <= 1'b0;
        end
    end

    // Load return path; data and size code hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_valid_r <= 1'b0;
            ld_whb_r   <= 3'b000;
            ld_data_r  <= 32'h0000_0000;
        end else begin
            ld_valid_r <= done_s && lat_load_r;
            if (done_s && lat_load_r) begin
                ld_whb_r  <= lat_whb_r;
                ld_data_r <= ld_aligned_s;
            end
        end
    end

    // Single-cycle exception and bus-error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_exc_r <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            lsu_exc_r <= illegal_s;
            bus_err_r <= timeout_s;
        end
    end

    assign dm_req   = dm_req_r;
    assign dm_we    = dm_we_r;
    assign dm_addr  = dm_addr_r;
    assign dm_wdata = dm_wdata_r;
    assign ld_valid = ld_valid_r;
    assign ld_whb   = ld_whb_r;
    assign ld_data  = ld_data_r;
    assign lsu_exc  = lsu_exc_r;
    assign bus_err  = bus_err_r;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: directed accesses push expected events, a monitor checks them.
module tb_lsu_dmem_ctrl;
    import lsu_dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_whb;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_stall, dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        ld_valid;
    logic [2:0]  ld_whb;
    logic [31:0] ld_data;
    logic        lsu_exc, bus_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          chk_wd;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [2:0]  whb;
    } ld_t;

    req_t req_q[$];
    ld_t  ld_q[$];
    int   exc_q[$];
    int   berr_q[$];

    lsu_dmem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_whb(ex_whb), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_stall(lsu_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ld_valid(ld_valid), .ld_whb(ld_whb), .ld_data(ld_data),
        .lsu_exc(lsu_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input int c, input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input bit chk_wd);
        req_t r;
        r.cyc = c; r.addr = a; r.we = we; r.wdata = wd; r.chk_wd = chk_wd;
        req_q.push_back(r);
    endtask

    task automatic push_ld(input int c, input logic [31:0] d, input logic [2:0] w);
        ld_t l;
        l.cyc = c; l.data = d; l.whb = w;
        ld_q.push_back(l);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dm_req"},   {31'h0, dm_req},   32'h0);
        chk({tag, "_dm_we"},    {28'h0, dm_we},    32'h0);
        chk({tag, "_dm_addr"},  dm_addr,           32'h0);
        chk({tag, "_dm_wdata"}, dm_wdata,          32'h0);
        chk({tag, "_ld_valid"}, {31'h0, ld_valid}, 32'h0);
        chk({tag, "_ld_whb"},   {29'h0, ld_whb},   32'h0);
        chk({tag, "_ld_data"},  ld_data,           32'h0);
        chk({tag, "_lsu_exc"},  {31'h0, lsu_exc},  32'h0);
        chk({tag, "_bus_err"},  {31'h0, bus_err},  32'h0);
    endtask

    // Drives one access from a post-edge point; ack_at is the cycle offset of dm_ack (0 = never).
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] whb,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata,
                           input int ncyc, input int exp_stall, input string name);
        int stalls;
        stalls   = 0;
        ex_valid = 1'b1; ex_load = ld; ex_store = st;
        ex_whb   = whb;  ex_addr = addr; ex_wdata = wdata;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (lsu_stall) stalls++;
            @(posedge clk); #1;
            ex_valid = 1'b0;
            dm_ack   = (c + 1 == ack_at);
            dm_rdata = (c + 1 == ack_at) ? rdata : 32'h0;
        end
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        chk({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    // Monitor: every DUT output event must match the head of its expectation queue.
    initial begin
        logic prev_req;
        req_t r;
        ld_t  l;
        int   e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (dm_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 32'h1, 32'h0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_cycle", cyc, r.cyc);
                        chk("req_addr", dm_addr, r.addr);
                        chk("req_we", {28'h0, dm_we}, {28'h0, r.we});
                        if (r.chk_wd) chk("req_wdata", dm_wdata, r.wdata);
                    end
                end
                prev_req = dm_req;
                if (ld_valid) begin
                    if (ld_q.size() == 0) begin
                        chk("ld_unexpected", 32'h1, 32'h0);
                    end else begin
                        l = ld_q.pop_front();
                        chk("ld_cycle", cyc, l.cyc);
                        chk("ld_data", ld_data, l.data);
                        chk("ld_whb", {29'h0, ld_whb}, {29'h0, l.whb});
                    end
                end
                if (lsu_exc) begin
                    if (exc_q.size() == 0) chk("exc_unexpected", 32'h1, 32'h0);
                    else begin e = exc_q.pop_front(); chk("exc_cycle", cyc, e); end
                end
                if (bus_err) begin
                    if (berr_q.size() == 0) chk("berr_unexpected", 32'h1, 32'h0);
                    else begin e = berr_q.pop_front(); chk("berr_cycle", cyc, e); end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_whb = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
        dm_ack = 1'b0; dm_rdata = 32'h0;
        #2;
        check_all_zero("reset");
        chk("reset_stall", {31'h0, lsu_stall}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SB to the top byte lane, ack on the second request cycle
        push_req(cyc + 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b1);
        run_txn(1'b0, 1'b1, WHB_BYTE, 32'h0000_1003, 32'h0000_00AB, 2, 32'h0, 4, 3, "sb");

        // SH upper half and a BYTEU-coded store
        push_req(cyc + 1, 32'h0000_2000, 4'b1100, 32'hCDEF_CDEF, 1'b1);
        run_txn(1'b0, 1'b1, WHB_HALF, 32'h0000_2002, 32'h1234_CDEF, 1, 32'h0, 3, 2, "sh");
        push_req(cyc + 1, 32'h0000_1000, 4'b0010, 32'h5555_5555, 1'b1);
        run_txn(1'b0, 1'b1, WHB_BYTEU, 32'h0000_1001, 32'hFFFF_FF55, 1, 32'h0, 3, 2, "sbu");

        // LH upper half, ack in N+1
        push_req(cyc + 1, 32'h0000_2000, 4'b0000, 32'h0, 1'b0);
        push_ld(cyc + 2, 32'h0000_8765, WHB_HALF);
        run_txn(1'b1, 1'b0, WHB_HALF, 32'h0000_2002, 32'h0, 1, 32'h8765_4321, 3, 2, "lh");

        // ld_data holds, and an ack while idle does nothing
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = 32'h0;
        @(negedge clk);
        chk("hold_ld_data", ld_data, 32'h0000_8765);
        chk("hold_ld_whb", {29'h0, ld_whb}, {29'h0, WHB_HALF});
        @(posedge clk); #1;

        // LB of the top byte: raw, not extended
        push_req(cyc + 1, 32'h0000_6000, 4'b0000, 32'h0, 1'b0);
        push_ld(cyc + 2, 32'h0000_0080, WHB_BYTE);
        run_txn(1'b1, 1'b0, WHB_BYTE, 32'h0000_6003, 32'h0, 1, 32'h80FF_FFFF, 3, 2, "lb");

        // Illegal accesses: misaligned word, misaligned half store, load&store
        exc_q.push_back(cyc + 1);
        run_txn(1'b1, 1'b0, WHB_WORD, 32'h0000_3001, 32'h0, 0, 32'h0, 3, 0, "lw_misal");
        exc_q.push_back(cyc + 1);
        run_txn(1'b0, 1'b1, WHB_HALF, 32'h0000_2001, 32'h0, 0, 32'h0, 3, 0, "sh_misal");
        exc_q.push_back(cyc + 1);
        run_txn(1'b1, 1'b1, WHB_WORD, 32'h0000_0000, 32'h0, 0, 32'h0, 3, 0, "ldst");

        // LW with no ack: bus error after four wait cycles
        push_req(cyc + 1, 32'h0000_3000, 4'b0000, 32'h0, 1'b0);
        berr_q.push_back(cyc + 5);
        run_txn(1'b1, 1'b0, WHB_WORD, 32'h0000_3000, 32'h0, 0, 32'h0, 7, 5, "timeout");
        @(negedge clk);
        chk("timeout_req_low", {31'h0, dm_req}, 32'h0);
        @(posedge clk); #1;

        // Reset asserted while a request is in flight
        push_req(cyc + 1, 32'h0000_7000, 4'b1111, 32'h1357_9BDF, 1'b1);
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_whb = WHB_WORD;
        ex_addr = 32'h0000_7000; ex_wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        chk("midreset_stall", {31'h0, lsu_stall}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LBU after reset
        push_req(cyc + 1, 32'h0000_4000, 4'b0000, 32'h0, 1'b0);
        push_ld(cyc + 2, 32'h0000_0033, WHB_BYTEU);
        run_txn(1'b1, 1'b0, WHB_BYTEU, 32'h0000_4001, 32'h0, 1, 32'h1122_3344, 3, 2, "lbu");

        // Back-to-back SW then LW of the same word
        push_req(cyc + 1, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        push_req(cyc + 3, 32'h0000_5000, 4'b0000, 32'h0, 1'b0);
        push_ld(cyc + 4, 32'hDEAD_BEEF, WHB_WORD);
        run_txn(1'b0, 1'b1, WHB_WORD, 32'h0000_5000, 32'hDEAD_BEEF, 1, 32'h0, 2, 2, "sw_b2b");
        run_txn(1'b1, 1'b0, WHB_WORD, 32'h0000_5000, 32'h0, 1, 32'hDEAD_BEEF, 3, 2, "lw_b2b");

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 32'h0);
        chk("ld_q_drained", ld_q.size(), 32'h0);
        chk("exc_q_drained", exc_q.size(), 32'h0);
        chk("berr_q_drained", berr_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
